// File: rtl/comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and
// the {eq,gt,lt} result encodings used by the datapath and by checkers.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Result vectors are ordered {eq, gt, lt}; exactly one bit is set.
  localparam logic [2:0] RES_EQ = 3'b100;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/comparator_bit_cell.sv
// Combinational 1-bit magnitude compare cell; the sequential comparator
// walks one instance of it across the captured operands MSB-first.
module comparator_bit_cell (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = ~(a ^ b);
  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/comparator_seq_mag.sv
// Bit-serial unsigned magnitude comparator: captures an operand pair, scans
// MSB-first with one shared bit cell and stops at the first differing bit.
module comparator_seq_mag
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CNT_W-1:0] nbits
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Producers hold valid and data stable until the transfer; in_ready is high
  // only in IDLE and out_valid only in DONE, so accept and handoff never overlap.

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, out_valid_q;
  logic               eq_q, gt_q, lt_q;
  logic [CNT_W-1:0]   nbits_q;
  logic               cell_eq, cell_gt, cell_lt;

  comparator_bit_cell u_cell (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .eq (cell_eq),
    .gt (cell_gt),
    .lt (cell_lt)
  );

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      nbits_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            idx_q      <= IDX_W'(WIDTH - 1);
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CMP;
          end
        end
        CMP: begin
          cnt_q <= cnt_d;
          // A differing bit decides immediately; the idx==0 exit wins over
          // decrementing so idx never wraps.
          if (!cell_eq) begin
            eq_q        <= 1'b0;
            gt_q        <= cell_gt;
            lt_q        <= cell_lt;
            nbits_q     <= cnt_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (idx_q == '0) begin
            eq_q        <= 1'b1;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            nbits_q     <= CNT_W'(WIDTH);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          eq_q        <= 1'b0;
          gt_q        <= 1'b0;
          lt_q        <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign nbits     = nbits_q;

endmodule

// File: tb/tb_comparator_seq_mag.sv
// Directed bench for comparator_seq_mag (WIDTH=8): hand-computed results,
// latencies, backpressure, operand capture and asynchronous abort.
module tb_comparator_seq_mag;
  import comparator_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             eq, gt, lt;
  logic [CNT_W-1:0] nbits;

  int n_tests;
  int n_fail;

  comparator_seq_mag #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .nbits     (nbits)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one operand pair and checks latency, result and handoff.
  // hold > 0 keeps out_ready low for that many cycles of DONE while offering
  // a competing pair that must be ignored. scramble changes a/b during CMP.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] exp_res, input int exp_n,
                       input int hold, input bit scramble);
    int lat;
    out_ready = (hold == 0);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (scramble) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_n);
    check("result", {29'd0, eq, gt, lt}, {29'd0, exp_res});
    check("nbits", {28'd0, nbits}, exp_n);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = 8'hFF;
      b = 8'h00;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", {29'd0, eq, gt, lt}, {29'd0, exp_res});
      check("hold_nbits", {28'd0, nbits}, exp_n);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handoff_valid", {31'd0, out_valid}, 32'd0);
    check("handoff_flags", {29'd0, eq, gt, lt}, 32'd0);
    check("handoff_in_ready", {31'd0, in_ready}, 32'd1);
    check("handoff_nbits_held", {28'd0, nbits}, exp_n);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_flags", {29'd0, eq, gt, lt}, 32'd0);
    check("rst_nbits", {28'd0, nbits}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'hA5, 8'h25, RES_GT, 1, 0, 1'b0);
    do_op(8'h3C, 8'h3C, RES_EQ, 8, 0, 1'b0);
    do_op(8'h10, 8'h11, RES_LT, 8, 0, 1'b0);
    do_op(8'h40, 8'h00, RES_GT, 2, 0, 1'b0);
    do_op(8'h01, 8'h02, RES_LT, 7, 5, 1'b0);
    do_op(8'hFF, 8'h00, RES_GT, 1, 0, 1'b0);
    do_op(8'hF0, 8'hF1, RES_LT, 8, 0, 1'b1);
    do_op(8'h00, 8'hFF, RES_LT, 1, 0, 1'b0);

    // Abort an equal-operand compare in its third CMP cycle.
    a = 8'h3C;
    b = 8'h3C;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_flags", {29'd0, eq, gt, lt}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_nbits", {28'd0, nbits}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("no_stale_result", {31'd0, out_valid}, 32'd0);
    end

    do_op(8'h7F, 8'h7F, RES_EQ, 8, 0, 1'b0);
    do_op(8'h80, 8'h7F, RES_GT, 1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_seq_mag.md
Name: comparator_seq_mag

Overview:
- Sequential magnitude comparator with valid/ready handshakes on both sides.
- Accepts a WIDTH-bit operand pair and compares it MSB-first, one bit per cycle, using a 1-bit compare cell.
- Terminates early at the first differing bit and returns a one-hot eq/gt/lt result plus the number of bits examined.
- Serves as the consuming end of the operand stream in the comparator datapath, where a parallel equality check is insufficient and area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits; legal range ≥1.
- CNT_W, $clog2(WIDTH+1), width of the bits-examined count (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.
- nbits  output  CNT_W  bits examined before a decision, 1..WIDTH.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, eq=gt=lt=0, nbits=0, internal operand and index registers cleared. On release, the first accept is possible on the next rising edge.
- Every output is registered; there is no combinational path from inputs to outputs.
- States:
  - IDLE: in_ready=1. When in_valid&&in_ready, capture a and b, set idx=WIDTH-1, set cnt=0, go to CMP.
  - CMP: in_ready=0. Each cycle, the compare cell evaluates bit idx of the captured operands and cnt increments.
    - a[idx]!=b[idx]: latch gt=a[idx], lt=b[idx], eq=0, nbits=cnt+1, go to DONE.
    - bits equal and idx==0: latch eq=1, gt=lt=0, nbits=WIDTH, go to DONE.
    - otherwise: idx decrements and the block stays in CMP.
  - DONE: out_valid=1; eq/gt/lt/nbits stable. When out_ready is high, go to IDLE and clear out_valid, eq, gt, lt.
- Latency: with k bits examined, out_valid rises k cycles after the accepting edge. The range is 1 cycle (MSB differs) to WIDTH cycles (equal operands).
- Throughput: one operation at a time. in_ready=0 throughout CMP and DONE, so no new accept can occur in the same cycle as result handoff. The next accept is possible one cycle after handoff.
- Invariants:
  - exactly one of eq/gt/lt is high whenever out_valid=1;
  - all three are 0 whenever out_valid=0;
  - nbits holds until the next result.
- Input changes on a and b after acceptance have no effect; operands are captured.
- out_ready high in a non-DONE state is ignored. out_ready held low holds DONE and the result indefinitely.
- WIDTH=1: CMP lasts exactly one cycle, and nbits=1 always.
- Reset asserted mid-CMP or mid-DONE aborts the operation and produces no result; the block behaves as after power-up reset.
- idx never underflows; the CMP exit at idx==0 takes priority over decrement.

Decomposition:
- Shared package comparator_pkg:
  - state enum {IDLE, CMP, DONE} (2-bit encoding);
  - result encoding constants RES_EQ/RES_GT/RES_LT for benches and scoreboards.
- Sub-module comparator_bit_cell: combinational 1-bit compare with inputs a, b and outputs eq, gt, lt. It is instantiated once and indexed by idx.

Test Plan (WIDTH=8):
- Reset, then release; drive A=0xA5, B=0x25 with out_ready=1 -> accepted on the first edge; one cycle later out_valid=1, gt=1, nbits=1; in_ready returns to 1 on the cycle after handoff.
- A=0x3C, B=0x3C -> out_valid exactly 8 cycles after accept, eq=1, gt=lt=0, nbits=8.
- A=0x10, B=0x11 -> lt=1, nbits=8. A=0x40, B=0x00 -> gt=1, nbits=2.
- Backpressure: A=0x01, B=0x02 with out_ready=0 for 5 cycles -> out_valid, lt and nbits=7 held stable, in_ready=0 throughout, in_valid with new operands ignored; out_ready=1 -> handoff, then the new pair is accepted.
- Change a/b every cycle during CMP after accepting A=0xF0, B=0xF1 -> result lt=1, nbits=8 (captured values used).
- Assert rst_n=0 asynchronously mid-CMP (cycle 3 of an equal-operand compare) -> out_valid=0, eq/gt/lt=0, in_ready=1 immediately; no stale result appears after release.
